// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and field layout for the instruction-cache block fill engine.
// A 16-bit byte address splits as tag[15:10] / set[9:4] / offset[3:0].
package cache_fill_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int SET_W           = 6;
    localparam int TAG_W           = 6;
    localparam int OFF_W           = 4;
    localparam int NUM_SETS        = 1 << SET_W;
    localparam int TAG_OUT_W       = TAG_W + 2;
    localparam int TAG_VALID_BIT   = 7;
    localparam int TAG_LRU_BIT     = 6;

    // Metadata word for a freshly filled line: valid, LRU cleared, address tag.
    function automatic logic [TAG_OUT_W-1:0] make_tag(input logic [TAG_W-1:0] tag);
        logic [TAG_OUT_W-1:0] t;
        t                = '0;
        t[TAG_W-1:0]     = tag;
        t[TAG_VALID_BIT] = 1'b1;
        t[TAG_LRU_BIT]   = 1'b0;
        return t;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Memory-port handshake between the fill engine (master) and the arbiter/memory (slave).
interface cache_fill_fsm_if;
    import cache_fill_fsm_pkg::*;

    logic              mem_req;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_grant;
    logic [DATA_W-1:0] mem_data;
    logic              mem_data_valid;

    modport master (
        output mem_req, mem_rd_en, mem_address,
        input  mem_grant, mem_data, mem_data_valid
    );

    modport slave (
        input  mem_req, mem_rd_en, mem_address,
        output mem_grant, mem_data, mem_data_valid
    );

endinterface

// File: rtl/onehot_decoder.sv
// N-bit index to 2^N one-hot vector, all zero when not enabled.
module onehot_decoder #(
    parameter int N = 3
) (
    input  logic [N-1:0]        idx,
    input  logic                en,
    output logic [(1<<N)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Instruction-cache miss fill: requests the memory port, streams one 16B block
// into the victim way one word per cycle, then writes the tag and pulses fill_done.
module cache_fill_fsm #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = cache_fill_fsm_pkg::WORDS_PER_BLOCK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_detected,
    input  logic [15:0]                miss_address,
    input  logic                       victim_way,
    cache_fill_fsm_if.master           mem,
    output logic                       fsm_busy,
    output logic                       write_en_0,
    output logic                       write_en_1,
    output logic                       tag_write_0,
    output logic                       tag_write_1,
    output logic [WORDS_PER_BLOCK-1:0] word_sel,
    output logic [63:0]                block_sel,
    output logic [15:0]                data_out,
    output logic [7:0]                 tag_out,
    output logic                       fill_done
);
    import cache_fill_fsm_pkg::*;

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W:0]   ISSUE_END = (IDX_W + 1)'(WORDS_PER_BLOCK);

    // Address layout fixes the block at 8 halfwords; latency must be at least one cycle.
    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK != 8) begin : g_param_check
        $error("cache_fill_fsm: unsupported MEM_LATENCY/WORDS_PER_BLOCK");
    end

    state_t                      state, state_nxt;
    logic [ADDR_W-OFF_W-1:0]     base;
    logic                        way;
    logic [IDX_W:0]              issue_cnt;
    logic [IDX_W-1:0]            recv_cnt;
    logic [IDX_W-1:0]            wr_idx;
    logic                        wr_vld;
    logic                        blk_en;
    logic                        unused_offset_bits;

    assign unused_offset_bits = ^miss_address[OFF_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        mem.mem_req     = 1'b0;
        mem.mem_rd_en   = 1'b0;
        mem.mem_address = '0;
        fsm_busy        = 1'b0;
        tag_write_0     = 1'b0;
        tag_write_1     = 1'b0;
        tag_out         = '0;
        fill_done       = 1'b0;
        blk_en          = 1'b0;
        case (state)
            IDLE: begin
                if (miss_detected) state_nxt = REQ;
            end
            REQ: begin
                fsm_busy    = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_grant) state_nxt = FILL;
            end
            FILL: begin
                // Grant is assumed held until mem_req drops, so it is not re-checked here.
                fsm_busy    = 1'b1;
                mem.mem_req = 1'b1;
                blk_en      = 1'b1;
                if (issue_cnt != ISSUE_END) begin
                    mem.mem_rd_en   = 1'b1;
                    mem.mem_address = {base, issue_cnt[IDX_W-1:0], 1'b0};
                end
                if (mem.mem_data_valid && recv_cnt == LAST_WORD) state_nxt = DONE;
            end
            DONE: begin
                // The last word's registered write lands in this same cycle.
                fsm_busy    = 1'b1;
                blk_en      = 1'b1;
                tag_write_0 = ~way;
                tag_write_1 = way;
                tag_out     = make_tag(base[SET_W +: TAG_W]);
                fill_done   = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base      <= '0;
            way       <= 1'b0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            wr_idx    <= '0;
            wr_vld    <= 1'b0;
            data_out  <= '0;
        end else begin
            wr_vld <= 1'b0;
            if (state == IDLE && miss_detected) begin
                base      <= miss_address[ADDR_W-1:OFF_W];
                way       <= victim_way;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
            if (mem.mem_rd_en) issue_cnt <= issue_cnt + 1'b1;
            if (state == FILL && mem.mem_data_valid) begin
                wr_vld   <= 1'b1;
                wr_idx   <= recv_cnt;
                data_out <= mem.mem_data;
                recv_cnt <= recv_cnt + 1'b1;
            end
        end
    end

    assign write_en_0 = wr_vld & ~way;
    assign write_en_1 = wr_vld & way;

    onehot_decoder #(.N(IDX_W)) u_word_dec (
        .idx    (wr_idx),
        .en     (wr_vld),
        .onehot (word_sel)
    );

    onehot_decoder #(.N(SET_W)) u_set_dec (
        .idx    (base[SET_W-1:0]),
        .en     (blk_en),
        .onehot (block_sel)
    );

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, meaning cycles from mem_rd_en assertion to matching mem_data_valid.
REQ-002 SHALL have parameter WORDS_PER_BLOCK, default 8, meaning 16-bit words per 16B cache block.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 miss_detected  input  1  instruction cache miss on current fetch; level, held until fill_done.
REQ-006 miss_address  input  16  byte address of missing fetch.
REQ-007 victim_way  input  1  way chosen for replacement (0/1) by the LRU logic, sampled at fill start.
REQ-008 mem_grant  input  1  memory arbiter grants port to this requester.
REQ-009 mem_data  input  16  read data returned from main memory.
REQ-010 mem_data_valid  input  1  mem_data is valid this cycle.
REQ-011 mem_req  output  1  request memory port from arbiter.
REQ-012 mem_rd_en  output  1  read strobe, one word per cycle.
REQ-013 mem_address  output  16  word-aligned read address.
REQ-014 fsm_busy  output  1  fill in progress; pipeline fetch stalls.
REQ-015 write_en_0 / write_en_1  output  1 each  data-array write to way 0 / way 1.
REQ-016 tag_write_0 / tag_write_1  output  1 each  metadata write to way 0 / way 1.
REQ-017 word_sel  output  8  one-hot word enable into the data array.
REQ-018 block_sel  output  64  one-hot set enable (set = miss_address[9:4]).
REQ-019 data_out  output  16  data to write (registered mem_data).
REQ-020 tag_out  output  8  {valid=1, lru=0, miss_address[15:10]}.
REQ-021 fill_done  output  1  one-cycle pulse when block and tag are written.

Function
REQ-022 SHALL implement states IDLE, REQ, FILL, DONE.
REQ-023 IDLE -> REQ when miss_detected=1; latch miss_address[15:4], victim_way; fsm_busy=1 from the next cycle.
REQ-024 REQ: mem_req=1; -> FILL on the cycle mem_grant=1.
REQ-025 FILL: mem_rd_en=1 for exactly 8 consecutive cycles, mem_address={base[15:4], issue_cnt[2:0], 1'b0}, issue_cnt 0..7.
REQ-026 FILL: each mem_data_valid writes data_out, write_en_<victim_way>=1, word_sel=1<<recv_cnt; recv_cnt increments; order is in issue order.
REQ-027 Write of word N SHALL occur the cycle after its mem_data_valid (one registered stage).
REQ-028 FILL -> DONE on the write cycle of word 7 (recv_cnt wraps 7->0 exactly once per fill).
REQ-029 DONE (one cycle): tag_write_<victim_way>=1, tag_out driven, fill_done=1, mem_req=0; -> IDLE.
REQ-030 Total fill latency from grant SHALL be 8+MEM_LATENCY+1 cycles to fill_done (13 at default).
REQ-031 block_sel SHALL be one-hot of latched set during all writes; 0 in IDLE/REQ.
REQ-032 miss_detected changes while busy SHALL be ignored; new fill only from IDLE.
REQ-033 mem_data_valid in IDLE/REQ/DONE SHALL be ignored (no writes).
REQ-034 mem_grant deassertion during FILL SHALL be ignored (grant held by arbiter until mem_req drops).
REQ-035 write_en_* and tag_write_* of the non-victim way SHALL never assert.

Reset
REQ-036 rst=0 at a clock edge SHALL force IDLE, counters 0, all outputs 0, including mid-fill (partial block left with tag untouched, so the set stays invalid/stale).
REQ-037 After rst releases, a held miss_detected SHALL start a fresh fill from word 0.

Structure
REQ-038 Shared package SHALL hold the state enum, WORDS_PER_BLOCK, set/tag/offset field widths (6/6/4) and the tag valid/lru bit positions.
REQ-039 Counters and FSM SHALL stay in this module; one sub-module, onehot_decoder (parameterised N->2^N), SHALL generate word_sel and block_sel.

Verification
REQ-040 Miss at 0x1234, victim_way=1, grant after 2 cycles -> addresses 0x1230..0x123E, 8 writes to way 1 set 35, tag_out=0x84, fill_done 13 cycles after grant.
REQ-041 Miss with victim_way=0 at 0xFFF0 -> block_sel bit 63, word_sel 0x01..0x80 in order, write_en_1 never high.
REQ-042 rst=0 after 3rd word written -> all outputs 0 next cycle; re-miss restarts at word 0 and completes normally.
REQ-043 Spurious mem_data_valid in IDLE and second miss pulse mid-FILL -> no extra writes, single fill_done.
REQ-044 Grant withheld 20 cycles -> fsm_busy and mem_req stay 1, mem_rd_en 0 until grant.
